// File: rtl/matmul_seq_ctrl.sv
// Matrix-multiply sequencer. Captures two packed n x n matrices, feeds one
// row/column pair at a time to an external dot-product unit (row_col) in
// row-major order, and assembles the returned dot products into mat_c.
module matmul_seq_ctrl #(
  parameter int unsigned width   = 32,
  parameter int unsigned n       = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [width*n*n-1:0]   mat_a,
  input  logic [width*n*n-1:0]   mat_b,
  output logic [width*n-1:0]     dp_a,
  output logic [width*n-1:0]     dp_b,
  output logic                   dp_start,
  input  logic [width-1:0]       dp_c,
  input  logic                   dp_done,
  output logic [width*n*n-1:0]   mat_c,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned IW = $clog2(n) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LastIdx = IW'(n - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StStore,
    StDrain,
    StDone
  } state_e;

  state_e                 state_q;
  logic [width*n*n-1:0]   a_q;
  logic [width*n*n-1:0]   b_q;
  logic [IW-1:0]          i_q;
  logic [IW-1:0]          j_q;
  logic [TW-1:0]          tmo_q;
  logic [width-1:0]       hold_q;

  // Row i of a packed matrix: element k lands at [width*k +: width].
  function automatic logic [width*n-1:0] row_of(input logic [width*n*n-1:0] m,
                                                input logic [IW-1:0] i);
    logic [width*n-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < n; k++) begin
      r[width*k +: width] = m[width*(32'(i)*n + k) +: width];
    end
    return r;
  endfunction

  // Column j of a packed matrix: element k lands at [width*k +: width].
  function automatic logic [width*n-1:0] col_of(input logic [width*n*n-1:0] m,
                                                input logic [IW-1:0] j);
    logic [width*n-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < n; k++) begin
      c[width*k +: width] = m[width*(k*n + 32'(j)) +: width];
    end
    return c;
  endfunction

  // Sequencer FSM; every output is registered. dp_a/dp_b/dp_start are loaded
  // on the edge that enters LOAD so the start pulse and operands coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      tmo_q    <= '0;
      hold_q   <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_start <= 1'b0;
      mat_c    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q      <= mat_a;
            b_q      <= mat_b;
            mat_c    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            error    <= 1'b0;
            // Captured copies are not visible yet, so use the live inputs.
            dp_a     <= row_of(mat_a, '0);
            dp_b     <= col_of(mat_b, '0);
            dp_start <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          dp_start <= 1'b0;
          tmo_q    <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          if (dp_done) begin
            hold_q  <= dp_c;
            state_q <= StStore;
          end else if (tmo_q == TmoLast) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StStore: begin
          mat_c[width*(32'(i_q)*n + 32'(j_q)) +: width] <= hold_q;
          if (j_q < LastIdx) begin
            j_q     <= j_q + IW'(1);
            state_q <= StDrain;
          end else if (i_q < LastIdx) begin
            j_q     <= '0;
            i_q     <= i_q + IW'(1);
            state_q <= StDrain;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDrain: begin
          // A level-type done from the previous element must drop first.
          if (!dp_done) begin
            dp_a     <= row_of(a_q, i_q);
            dp_b     <= col_of(b_q, j_q);
            dp_start <= 1'b1;
            state_q  <= StLoad;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a behavioural dot-product responder.
module tb_matmul_seq_ctrl;

  localparam int W   = 32;
  localparam int N   = 3;
  localparam int TMO = 16;

  logic           clk;
  logic           rst;
  logic           start;
  logic [287:0]   mat_a;
  logic [287:0]   mat_b;
  logic [95:0]    dp_a;
  logic [95:0]    dp_b;
  logic           dp_start;
  logic [31:0]    dp_c;
  logic           dp_done;
  logic [287:0]   mat_c;
  logic           busy;
  logic           done;
  logic           error;

  int checks;
  int errors;

  // Responder configuration and log, shared with the stimulus thread.
  int           lat;
  int           hold;
  int           stall_at;
  int           starts;
  logic [95:0]  log_a [64];
  logic [95:0]  log_b [64];

  matmul_seq_ctrl #(
    .width  (W),
    .n      (N),
    .TIMEOUT(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mat_a   (mat_a),
    .mat_b   (mat_b),
    .dp_a    (dp_a),
    .dp_b    (dp_b),
    .dp_start(dp_start),
    .dp_c    (dp_c),
    .dp_done (dp_done),
    .mat_c   (mat_c),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [287:0] m3(input int unsigned v0, v1, v2, v3, v4, v5, v6, v7,
                                      v8);
    return {v8, v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  function automatic logic [95:0] r3(input int unsigned v0, v1, v2);
    return {v2, v1, v0};
  endfunction

  // Dot-product responder: done rises lat cycles after the start cycle and is
  // held for hold cycles; the start numbered stall_at never gets an answer.
  initial begin
    int          cnt;
    int          hl;
    logic        pend;
    logic [31:0] res;
    dp_done = 1'b0;
    dp_c    = '0;
    cnt     = 0;
    hl      = 0;
    pend    = 1'b0;
    res     = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend    = 1'b0;
        hl      = 0;
        dp_done = 1'b0;
      end else begin
        if (hl > 0) begin
          hl--;
          if (hl == 0) dp_done = 1'b0;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend    = 1'b0;
            dp_done = 1'b1;
            dp_c    = res;
            hl      = hold;
          end
        end
        if (dp_start) begin
          if (starts < 64) begin
            log_a[starts] = dp_a;
            log_b[starts] = dp_b;
          end
          res = '0;
          for (int k = 0; k < N; k++) res += dp_a[32*k +: 32] * dp_b[32*k +: 32];
          pend = (starts != stall_at);
          cnt  = lat;
          starts++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [287:0] a, input logic [287:0] b);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, output int nc);
    nc = 0;
    while (!done && nc < maxc) begin
      tick();
      nc++;
    end
    check(tag, 288'(done), 288'(1));
  endtask

  initial begin
    logic [287:0] ma, mi, mb2, mc, mpart;
    logic [95:0]  row_a [3];
    logic [95:0]  col_b [3];
    int           nc;
    int           base;

    checks   = 0;
    errors   = 0;
    lat      = 1;
    hold     = 1;
    stall_at = -1;
    starts   = 0;

    ma    = m3(1, 2, 3, 4, 5, 6, 7, 8, 9);
    mi    = m3(1, 0, 0, 0, 1, 0, 0, 0, 1);
    mb2   = m3(9, 8, 7, 6, 5, 4, 3, 2, 1);
    mc    = m3(30, 24, 18, 84, 69, 54, 138, 114, 90);
    mpart = m3(30, 24, 18, 0, 0, 0, 0, 0, 0);
    row_a[0] = r3(1, 2, 3);
    row_a[1] = r3(4, 5, 6);
    row_a[2] = r3(7, 8, 9);
    col_b[0] = r3(9, 6, 3);
    col_b[1] = r3(8, 5, 2);
    col_b[2] = r3(7, 4, 1);

    // Reset state
    rst   = 1'b1;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_dp_a", 288'(dp_a), '0);
    check("reset_dp_b", 288'(dp_b), '0);
    check("reset_mat_c", mat_c, '0);
    check("reset_flags", 288'({dp_start, busy, done, error}), '0);

    // Identity with ideal responder; also checks the 4*n*n-1 latency
    lat  = 1;
    hold = 1;
    base = starts;
    go(ma, mi);
    check("id_busy", 288'(busy), 288'(1));
    wait_done("id_done", 100, nc);
    check("id_latency", 288'(nc), 288'(35));
    check("id_mat_c", mat_c, ma);
    check("id_error", 288'(error), '0);
    check("id_busy_low", 288'(busy), '0);
    check("id_starts", 288'(starts - base), 288'(9));

    // General product with slow, level-type done
    lat  = 5;
    hold = 3;
    base = starts;
    go(ma, mb2);
    wait_done("gen_done", 300, nc);
    check("gen_mat_c", mat_c, mc);
    check("gen_starts", 288'(starts - base), 288'(9));
    for (int k = 0; k < 9; k++) begin
      check($sformatf("gen_order_a%0d", k), 288'(log_a[base+k]), 288'(row_a[k/3]));
      check($sformatf("gen_order_b%0d", k), 288'(log_b[base+k]), 288'(col_b[k%3]));
    end

    // Start while busy plus input change is ignored
    lat  = 1;
    hold = 1;
    base = starts;
    go(ma, mb2);
    repeat (10) tick();
    check("busy_mid", 288'(busy), 288'(1));
    mat_a = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_restart", 288'(busy), 288'(1));
    check("done_after_restart", 288'(done), '0);
    wait_done("busy_done", 100, nc);
    check("busy_mat_c", mat_c, mc);
    check("busy_starts", 288'(starts - base), 288'(9));

    // Timeout on element (1,0)
    base     = starts;
    stall_at = base + 3;
    go(ma, mb2);
    wait_done("to_done", 100, nc);
    stall_at = -1;
    check("to_latency", 288'(nc), 288'(29));
    check("to_error", 288'(error), 288'(1));
    check("to_busy", 288'(busy), '0);
    check("to_starts", 288'(starts - base), 288'(4));
    check("to_mat_c", mat_c, mpart);

    // Reset during WAIT of element (1,1); start from DONE clears error
    lat  = 5;
    hold = 1;
    base = starts;
    go(ma, mb2);
    check("rs_error_cleared", 288'(error), '0);
    check("rs_done_low", 288'(done), '0);
    nc = 0;
    while (starts < base + 5 && nc < 200) begin
      tick();
      nc++;
    end
    check("rs_reach", 288'(starts - base), 288'(5));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_dp_a", 288'(dp_a), '0);
    check("rs_dp_b", 288'(dp_b), '0);
    check("rs_mat_c", mat_c, '0);
    check("rs_flags", 288'({dp_start, busy, done, error}), '0);
    base = starts;
    repeat (20) tick();
    check("rs_no_start", 288'(starts - base), '0);
    check("rs_idle_busy", 288'(busy), '0);
    lat = 1;
    go(ma, mi);
    wait_done("rs_fresh_done", 100, nc);
    check("rs_fresh_mat_c", mat_c, ma);
    check("rs_fresh_starts", 288'(starts - base), 288'(9));

    // Back-to-back run from DONE
    go(mi, mi);
    check("b2b_cleared", mat_c, '0);
    check("b2b_busy", 288'(busy), 288'(1));
    check("b2b_done_low", 288'(done), '0);
    wait_done("b2b_done", 100, nc);
    check("b2b_mat_c", mat_c, mi);
    check("b2b_error", 288'(error), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Sequencer that sits directly upstream of the row_col dot-product unit and also collects its results. On start it captures two packed N×N matrices A and B. For each output element (i,j) it presents row i of A and column j of B to row_col, pulses its start, waits for its done, and stores c into the packed result matrix C. Elements are dispatched in row-major order; the block raises done when all N×N elements are complete.

Parameters:
width, 32, bits per matrix element and per dot-product result
n, 3, matrix dimension (N); n >= 1
TIMEOUT, 1024, max cycles to wait for dp_done per element before aborting with error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a new multiplication; sampled only in IDLE or DONE
mat_a  in  width*n*n  matrix A; A[i][j] at bits [width*(i*n+j) +: width]
mat_b  in  width*n*n  matrix B, same packing as mat_a
dp_a  out  width*n  row i of A to row_col; A[i][k] at [width*k +: width]
dp_b  out  width*n  column j of B to row_col; B[k][j] at [width*k +: width]
dp_start  out  1  one-cycle start pulse to row_col
dp_c  in  width  row_col result c
dp_done  in  1  row_col done; pulse or level are both accepted
mat_c  out  width*n*n  result C; C[i][j] at [width*(i*n+j) +: width]
busy  out  1  high from start acceptance until DONE is reached
done  out  1  high while in DONE
error  out  1  set on timeout; cleared by start or rst

Behaviour:
- Reset (rst=1 at edge): state IDLE; dp_a, dp_b, mat_c all zero; dp_start=0, busy=0, done=0, error=0; row, col and timeout counters zero. rst overrides everything, including mid-operation; no further dp_start is issued.
- FSM states: IDLE, LOAD, WAIT, STORE, DRAIN, DONE.
- IDLE/DONE with start=1:
  - register mat_a/mat_b internally; later input changes are ignored until the next accepted start.
  - clear mat_c to 0, set i=j=0, clear error.
  - go to LOAD, busy=1, done=0.
- start while busy is ignored.
- LOAD (1 cycle):
  - drive dp_a=row i, dp_b=col j from the captured copies.
  - dp_start=1 for this cycle only, then go to WAIT.
  - dp_a/dp_b are registered and stay stable from LOAD until leaving STORE.
- WAIT:
  - count cycles.
  - on the first cycle with dp_done=1, latch dp_c into a holding register and go to STORE.
  - if the count reaches TIMEOUT without dp_done: error=1, go to DONE; mat_c keeps only the elements already stored.
- STORE (1 cycle): write the holding register to C[i][j] in mat_c.
  - if j<n-1: j++.
  - else if i<n-1: j=0, i++.
  - else the last element was stored: go to DONE.
  - otherwise go to DRAIN.
- DRAIN: wait until dp_done=0, then go to LOAD. This prevents a level-type done from the previous element being consumed twice. For pulse-type done it is normally a 1-cycle pass-through.
- DONE: busy=0, done=1 (level), mat_c holds. Leave only on start (new run) or rst.
- Index wrap: i and j run 0..n-1 with no wrap past n-1.
- Counter sizing:
  - i and j counters are clog2(n)+1 bits.
  - timeout counter is sized for TIMEOUT.
- Arithmetic: no arithmetic on data; dp_c is stored verbatim (width bits).
- Latency with an ideal dp (dp_done one cycle after dp_start), per element: LOAD 1 + WAIT 1 + STORE 1 + DRAIN 1 = 4 cycles. Total from start acceptance to done rising = 4*n*n - 1 cycles (no DRAIN after the last element).
- Exactly n*n dp_start pulses per successful run.

Test Plan:
- Identity: A=[[1,2,3],[4,5,6],[7,8,9]], B=I, with a behavioural dp model (pulse done, 1-cycle latency) -> mat_c equals A; done=1; error=0; exactly 9 dp_start pulses.
- General product: same A, B=[[9,8,7],[6,5,4],[3,2,1]], dp model with 5-cycle latency and level done held 3 cycles -> C=[[30,24,18],[84,69,54],[138,114,90]]; 9 dp_start pulses (no double-consume); dispatch order (0,0),(0,1)…(2,2) confirmed via dp_a/dp_b.
- Start while busy plus input change: pulse start again mid-run and change mat_a to all zeros -> ignored; result still matches the captured matrices; busy stays high.
- Timeout: TIMEOUT=16; dp model never returns done on element (1,0) -> after 16 WAIT cycles error=1, done=1, busy=0; C[0][0..2] correct, remaining elements zero.
- Reset mid-operation: assert rst during WAIT of element (1,1) -> next cycle IDLE with all outputs zero, no further dp_start. A fresh start then completes correctly.
- Back-to-back runs: start asserted in DONE with new matrices (A=B=I) -> mat_c cleared at acceptance, final mat_c = I, error=0.
